// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: drives one command byte to the device
// over open-drain clock/data using a device-clocked frame with timeouts.
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ      = 40000000,
  parameter int INHIBIT_US       = 100,
  parameter int START_TIMEOUT_US = 15000,
  parameter int FRAME_TIMEOUT_US = 2000,
  parameter int FILT_LEN         = 8
) (
  input  logic       clk_i,
  input  logic       res_n_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_done_o,
  output logic       tx_error_o,
  output logic       busy_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o
);

  localparam int CYC_PER_US  = CLK_FREQ_HZ / 1000000;
  localparam int INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
  localparam int START_CYC   = CYC_PER_US * START_TIMEOUT_US;
  localparam int FRAME_CYC   = CYC_PER_US * FRAME_TIMEOUT_US;
  localparam int MAX_A       = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
  localparam int MAX_CYC     = (MAX_A > FRAME_CYC) ? MAX_A : FRAME_CYC;
  localparam int TW          = $clog2(MAX_CYC + 1);
  localparam int FW          = $clog2(FILT_LEN + 1);

  localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] START_LAST = TW'(START_CYC - 1);
  localparam logic [TW-1:0] FRAME_LAST = TW'(FRAME_CYC - 1);
  localparam logic [FW-1:0] FILT_LAST  = FW'(FILT_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAITREL
  } state_t;

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_s, data_s;
  logic          filt_q, fall_q;
  logic [FW-1:0] filt_cnt_q;

  state_t        state_q, state_d;
  logic [8:0]    shift_q, shift_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          data_oe_q, data_oe_d;
  logic          ack_q, ack_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  // Two-stage synchronizers; idle bus level is high.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
    end
  end

  // Clock deglitch: accept a new level after FILT_LEN equal samples; strobe falls.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (clk_s == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FILT_LAST) begin
        filt_q     <= clk_s;
        filt_cnt_q <= '0;
        fall_q     <= filt_q;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

  // Frame sequencer state register.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      timer_q   <= '0;
      data_oe_q <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      timer_q   <= timer_d;
      data_oe_q <= data_oe_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic; data only changes on a filtered falling edge.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    timer_d   = timer_q + 1'b1;
    data_oe_d = data_oe_q;
    ack_d     = ack_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d   = '0;
        data_oe_d = 1'b0;
        if (tx_valid_i) begin
          shift_d  = {~^tx_data_i, tx_data_i};
          bitcnt_d = '0;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        data_oe_d = 1'b0;
        if (timer_q == INH_LAST) begin
          data_oe_d = 1'b1;
          timer_d   = '0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (timer_q == START_LAST) begin
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_IDLE;
        end else if (fall_q) begin
          data_oe_d = ~shift_q[0];
          bitcnt_d  = 4'd1;
          timer_d   = '0;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (timer_q == FRAME_LAST) begin
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_IDLE;
        end else if (fall_q) begin
          if (bitcnt_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = S_ACK;
          end else begin
            data_oe_d = ~shift_q[bitcnt_q];
            bitcnt_d  = bitcnt_q + 1'b1;
          end
        end
      end
      S_ACK: begin
        data_oe_d = 1'b0;
        if (timer_q == FRAME_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (fall_q) begin
          ack_d   = ~data_s;
          state_d = S_WAITREL;
        end
      end
      S_WAITREL: begin
        timer_d   = timer_q;
        data_oe_d = 1'b0;
        if (filt_q && data_s) begin
          done_d  = ack_q;
          err_d   = ~ack_q;
          state_d = S_IDLE;
        end
      end
      default: begin
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  assign tx_ready_o    = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign tx_done_o     = done_q;
  assign tx_error_o    = err_q;
  assign ps2_clk_oe_o  = (state_q == S_INHIBIT);
  assign ps2_data_oe_o = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple device model on the wires.
module tb_ps2_host_tx;
  localparam int HALF = 80;  // device half clock period in sys cycles

  logic       clk_i = 1'b0;
  logic       res_n_i = 1'b0;
  logic [7:0] tx_data_i = '0;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o, tx_done_o, tx_error_o, busy_o;
  logic       ps2_clk_i, ps2_data_i, ps2_clk_oe_o, ps2_data_oe_o;
  logic       dev_clk = 1'b1, dev_data = 1'b1;

  int n_chk = 0, n_pass = 0;
  int done_cnt = 0, err_cnt = 0, inh_cnt = 0;
  logic [10:0] rx_bits;  // [0]=start, [1..8]=data, [9]=parity, [10]=stop

  assign ps2_clk_i  = dev_clk  & ~ps2_clk_oe_o;
  assign ps2_data_i = dev_data & ~ps2_data_oe_o;

  ps2_host_tx #(.START_TIMEOUT_US(200)) dut (
    .clk_i(clk_i), .res_n_i(res_n_i), .tx_data_i(tx_data_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_done_o(tx_done_o),
    .tx_error_o(tx_error_o), .busy_o(busy_o), .ps2_clk_i(ps2_clk_i),
    .ps2_data_i(ps2_data_i), .ps2_clk_oe_o(ps2_clk_oe_o),
    .ps2_data_oe_o(ps2_data_oe_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (tx_done_o)    done_cnt++;
    if (tx_error_o)   err_cnt++;
    if (ps2_clk_oe_o) inh_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  // Request one byte; returns with the accept edge just past.
  task automatic start_tx(input logic [7:0] b);
    int n = 0;
    while (!tx_ready_o && n < 1000) begin tick(); n++; end
    tx_data_i = b; tx_valid_i = 1'b1;
    tick();
    tx_valid_i = 1'b0; tx_data_i = 8'h00;
  endtask

  // Device: wait for clock release, then clock nclk falls (clock left low
  // after the last one if nclk < 11); samples the wire on each rise.
  task automatic dev_frame(input bit ack, input int nclk, input bit glitch);
    int n = 0;
    rx_bits = '1;
    while (ps2_clk_oe_o && n < 20000) begin tick(); n++; end
    tick(40);
    rx_bits[0] = ps2_data_i;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      tick(HALF);
      if (k == nclk && nclk < 11) return;
      if (k <= 10) rx_bits[k] = ps2_data_i;
      dev_clk = 1'b1;
      if (glitch && k == 3) begin
        tick(20); dev_clk = 1'b0; tick(3); dev_clk = 1'b1; tick(HALF - 23);
      end else begin
        tick(HALF);
      end
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_pulse(input int d0, input int e0);
    int n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 400) begin tick(); n++; end
    tick(10);
  endtask

  // Full frame with ACK; checks wire bits and outcome.
  task automatic frame(input string tag, input logic [7:0] b, input logic par, input bit glitch);
    int d0, e0, i0;
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
    start_tx(b);
    dev_frame(1'b1, 11, glitch);
    chk({tag, "_inhibit"}, inh_cnt - i0, 4000);
    chk({tag, "_start"}, {31'd0, rx_bits[0]}, 0);
    chk({tag, "_byte"}, {24'd0, rx_bits[8:1]}, {24'd0, b});
    chk({tag, "_parity"}, {31'd0, rx_bits[9]}, {31'd0, par});
    chk({tag, "_stop"}, {31'd0, rx_bits[10]}, 1);
    wait_pulse(d0, e0);
    chk({tag, "_done"}, done_cnt - d0, 1);
    chk({tag, "_err"}, err_cnt - e0, 0);
    chk({tag, "_ready"}, {31'd0, tx_ready_o}, 1);
  endtask

  initial begin
    int d0, e0, n;
    #1;
    chk("rst_ready", {31'd0, tx_ready_o}, 1);
    chk("rst_busy", {31'd0, busy_o}, 0);
    chk("rst_done", {31'd0, tx_done_o}, 0);
    chk("rst_err", {31'd0, tx_error_o}, 0);
    chk("rst_clkoe", {31'd0, ps2_clk_oe_o}, 0);
    chk("rst_dataoe", {31'd0, ps2_data_oe_o}, 0);
    tick(3); res_n_i = 1'b1; tick(3);

    frame("ed", 8'hED, 1'b1, 1'b0);
    frame("f4", 8'hF4, 1'b0, 1'b0);
    frame("ff", 8'hFF, 1'b1, 1'b0);
    frame("glitch", 8'hED, 1'b1, 1'b1);

    // NACK: device leaves data high at the 11th clock
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hF4);
    chk("nack_busy", {31'd0, busy_o}, 1);
    dev_frame(1'b0, 11, 1'b0);
    wait_pulse(d0, e0);
    chk("nack_err", err_cnt - e0, 1);
    chk("nack_done", done_cnt - d0, 0);

    // Device never clocks: 4000 inhibit + 8000 start timeout
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hFF);
    n = 0;
    while (!tx_error_o && n < 20000) begin tick(); n++; end
    chk("to_latency_ok", {31'd0, (n >= 11990 && n <= 12010)}, 1);
    tick();
    chk("to_clkoe", {31'd0, ps2_clk_oe_o}, 0);
    chk("to_dataoe", {31'd0, ps2_data_oe_o}, 0);
    chk("to_ready", {31'd0, tx_ready_o}, 1);
    chk("to_errcnt", err_cnt - e0, 1);

    // Reset mid-frame while bit4 (0 for 0xED) is driven
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED);
    dev_frame(1'b1, 5, 1'b0);
    tick(5);
    chk("rstmid_pre_dataoe", {31'd0, ps2_data_oe_o}, 1);
    res_n_i = 1'b0;
    #1;
    chk("rstmid_clkoe", {31'd0, ps2_clk_oe_o}, 0);
    chk("rstmid_dataoe", {31'd0, ps2_data_oe_o}, 0);
    dev_clk = 1'b1; dev_data = 1'b1;
    tick(3); res_n_i = 1'b1; tick(300);
    chk("rstmid_ready", {31'd0, tx_ready_o}, 1);
    chk("rstmid_busy", {31'd0, busy_o}, 0);
    chk("rstmid_nopulse", (done_cnt - d0) + (err_cnt - e0), 0);

    // Back-to-back usability after reset
    frame("post", 8'hF4, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
